// File: rtl/chiplet_types_pkg.sv
// Shared link types for the chiplet switch: flit layout, VC index and egress FSM states.
package chiplet_types_pkg;

    localparam int unsigned LINK_NUM_VCS     = 2;
    localparam int unsigned LINK_VC_W        = (LINK_NUM_VCS > 1) ? $clog2(LINK_NUM_VCS) : 1;
    localparam int unsigned LINK_BUFFER_SIZE = 8;

    typedef logic [LINK_VC_W-1:0] vc_idx_t;

    typedef struct packed {
        vc_idx_t    vc;
        logic [6:0] dest;
    } flit_meta_t;

    typedef struct packed {
        flit_meta_t  metadata;
        logic [15:0] payload;
    } flit_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_CREDIT,
        SEND
    } egress_state_t;

endpackage

// File: rtl/egress_fifo.sv
// Small synchronous FIFO of flits; exposes the head and the entry behind it so the
// owner can work out the head that will be visible after a pop.
module egress_fifo
    import chiplet_types_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  flit_t            push_data,
    input  logic             pop,
    output flit_t            head,
    output flit_t            second,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    flit_t             mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_q;
    logic [PTR_W-1:0]  wr_q;
    logic [CNT_W-1:0]  count_q;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= ptr_inc(wr_q);
            if (pop)  rd_q <= ptr_inc(rd_q);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_data;
    end

    // Status and read ports.
    always_comb begin
        head   = mem_q[rd_q];
        second = mem_q[ptr_inc(rd_q)];
        count  = count_q;
        empty  = (count_q == '0);
        full   = (count_q == CNT_W'(DEPTH));
    end

endmodule

// File: rtl/switch_egress_port.sv
// Per-outport egress stage: buffers crossbar flits and forwards them onto the link
// only while the downstream per-VC buffer has credit. Strict in-order (HOL) service.
module switch_egress_port
    import chiplet_types_pkg::*;
#(
    parameter int unsigned NUM_VCS     = LINK_NUM_VCS,
    parameter int unsigned BUFFER_SIZE = LINK_BUFFER_SIZE,
    parameter int unsigned FIFO_DEPTH  = 2,
    localparam int unsigned VC_W  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            data_ready_in,
    input  flit_t                           flit_in,
    output logic                            packet_sent,
    output logic                            link_valid,
    output flit_t                           link_flit,
    input  logic                            link_ready,
    input  logic                            credit_return_valid,
    input  logic [VC_W-1:0]                 credit_return_vc,
    output logic [NUM_VCS-1:0]              credit_granted,
    output logic [NUM_VCS-1:0][CNT_W-1:0]   credits,
    output logic                            credit_overflow
);

    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

    egress_state_t                     state_q, state_d;
    logic [NUM_VCS-1:0][CNT_W-1:0]     credits_q, credits_d;
    logic [NUM_VCS-1:0]                grant_q, grant_d;
    logic                              overflow_q, overflow_d;

    flit_t                             fifo_head;
    flit_t                             fifo_second;
    logic                              fifo_full;
    logic                              fifo_empty;
    logic [FCNT_W-1:0]                 fifo_count;
    logic                              fifo_pop;

    logic [NUM_VCS-1:0]                send_vc;
    logic [NUM_VCS-1:0]                ret_vc;
    logic                              ret_ok;
    flit_t                             head_nxt;
    logic                              head_nxt_valid;
    logic                              head_nxt_ok;

    egress_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (packet_sent),
        .push_data (flit_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .second    (fifo_second),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Ingress/egress handshakes; full is pop-aware so a full FIFO can stream.
    always_comb begin
        fifo_pop    = (state_q == SEND) && link_ready && !n_rst;
        packet_sent = data_ready_in && (!fifo_full || fifo_pop) && !n_rst;
        link_valid  = (state_q == SEND);
        link_flit   = link_valid ? fifo_head : '0;
    end

    // Per-VC credit update: send/return on the same VC cancel; returns at the cap drop.
    always_comb begin
        credits_d  = credits_q;
        grant_d    = '0;
        send_vc    = '0;
        ret_vc     = '0;
        ret_ok     = credit_return_valid && (32'(credit_return_vc) < NUM_VCS);
        overflow_d = overflow_q || (credit_return_valid && !ret_ok);
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            send_vc[v] = fifo_pop && (32'(fifo_head.metadata.vc) == v);
            ret_vc[v]  = ret_ok && (32'(credit_return_vc) == v);
            if (send_vc[v] && ret_vc[v]) begin
                grant_d[v] = 1'b1;
            end else if (send_vc[v]) begin
                credits_d[v] = credits_q[v] - CNT_W'(1);
            end else if (ret_vc[v]) begin
                if (credits_q[v] == CNT_W'(BUFFER_SIZE)) begin
                    overflow_d = 1'b1;
                end else begin
                    credits_d[v] = credits_q[v] + CNT_W'(1);
                    grant_d[v]   = 1'b1;
                end
            end
        end
    end

    // Next state is judged on the head and credits as they will be after this edge,
    // which lets a freshly pushed flit go out the following cycle.
    always_comb begin
        if (fifo_pop) begin
            head_nxt_valid = (fifo_count > FCNT_W'(1)) || packet_sent;
            head_nxt       = (fifo_count > FCNT_W'(1)) ? fifo_second : flit_in;
        end else begin
            head_nxt_valid = !fifo_empty || packet_sent;
            head_nxt       = fifo_empty ? flit_in : fifo_head;
        end
        head_nxt_ok = 1'b0;
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            if ((32'(head_nxt.metadata.vc) == v) && (credits_d[v] != '0)) head_nxt_ok = 1'b1;
        end
        state_d = IDLE;
        if (head_nxt_valid) state_d = head_nxt_ok ? SEND : WAIT_CREDIT;
    end

    // State, credit counters, grant pulses and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q    <= IDLE;
            credits_q  <= {NUM_VCS{CNT_W'(BUFFER_SIZE)}};
            grant_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            grant_q    <= grant_d;
            overflow_q <= overflow_d;
        end
    end

    // Registered status outputs.
    always_comb begin
        credits         = credits_q;
        credit_granted  = grant_q;
        credit_overflow = overflow_q;
    end

endmodule

// File: tb/tb_switch_egress_port.sv
// Directed bench for switch_egress_port with an in-order flit scoreboard.
module tb_switch_egress_port;
    import chiplet_types_pkg::*;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             data_ready_in;
    flit_t            flit_in;
    logic             packet_sent;
    logic             link_valid;
    flit_t            link_flit;
    logic             link_ready;
    logic             credit_return_valid;
    logic [0:0]       credit_return_vc;
    logic [1:0]       credit_granted;
    logic [1:0][3:0]  credits;
    logic             credit_overflow;

    flit_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    pushed = 0;
    int    popped = 0;
    int    popped_mark;

    always #10 clk = ~clk;

    switch_egress_port #(
        .NUM_VCS     (2),
        .BUFFER_SIZE (8),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .data_ready_in       (data_ready_in),
        .flit_in             (flit_in),
        .packet_sent         (packet_sent),
        .link_valid          (link_valid),
        .link_flit           (link_flit),
        .link_ready          (link_ready),
        .credit_return_valid (credit_return_valid),
        .credit_return_vc    (credit_return_vc),
        .credit_granted      (credit_granted),
        .credits             (credits),
        .credit_overflow     (credit_overflow)
    );

    function automatic flit_t mk(input int vc, input int id);
        flit_t f;
        f.metadata.vc   = vc_idx_t'(vc);
        f.metadata.dest = 7'(id);
        f.payload       = 16'(id * 257 + 3);
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample mid-cycle: record accepted flits, compare departing ones, then move on.
    task automatic tick();
        flit_t f;
        #2;
        if (!n_rst) begin
            if (link_valid && link_ready) begin
                popped++;
                checks++;
                assert (exp_q.size() > 0)
                else begin
                    errors++;
                    $error("FAIL sb_unexpected_pop observed=%0h expected=none", link_flit);
                end
                if (exp_q.size() > 0) begin
                    f = exp_q.pop_front();
                    chk("sb_flit", 32'(link_flit), 32'(f));
                end
            end
            if (packet_sent) begin
                exp_q.push_back(flit_in);
                pushed++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst               = 1'b1;
        data_ready_in       = 1'b1;
        flit_in             = mk(0, 1);
        link_ready          = 1'b0;
        credit_return_valid = 1'b0;
        credit_return_vc    = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        // Reset state, with data_ready_in held high.
        chk("rst_credits0", 32'(credits[0]), 8);
        chk("rst_credits1", 32'(credits[1]), 8);
        chk("rst_link_valid", 32'(link_valid), 0);
        chk("rst_granted", 32'(credit_granted), 0);
        chk("rst_packet_sent", 32'(packet_sent), 0);
        chk("rst_overflow", 32'(credit_overflow), 0);

        // Single flit on vc 0.
        n_rst      = 1'b0;
        link_ready = 1'b1;
        #1;
        chk("single_packet_sent", 32'(packet_sent), 1);
        tick();
        data_ready_in = 1'b0;
        chk("single_link_valid", 32'(link_valid), 1);
        tick();
        chk("single_credits0", 32'(credits[0]), 7);
        chk("single_credits1", 32'(credits[1]), 8);
        chk("single_idle", 32'(link_valid), 0);
        chk("single_popped", 32'(popped), 1);

        // Drain vc 1 credits: 8 go out, 2 more fill the FIFO.
        data_ready_in = 1'b1;
        for (int i = 0; i < 40 && pushed < 11; i++) begin
            flit_in = mk(1, 100 + pushed);
            tick();
        end
        flit_in = mk(0, 30);
        tick();
        tick();
        #1;
        chk("vc1_full_blocks", 32'(packet_sent), 0);
        chk("vc1_wait_valid", 32'(link_valid), 0);
        chk("vc1_credits1", 32'(credits[1]), 0);
        chk("vc1_credits0", 32'(credits[0]), 7);
        chk("vc1_popped", 32'(popped), 9);

        // One return on vc 1 releases exactly one flit; full FIFO accepts during the pop.
        credit_return_valid = 1'b1;
        credit_return_vc    = 1'b1;
        tick();
        credit_return_valid = 1'b0;
        #1;
        chk("ret1_granted", 32'(credit_granted), 32'b10);
        chk("ret1_link_valid", 32'(link_valid), 1);
        chk("ret1_credits1", 32'(credits[1]), 1);
        chk("ret1_popaware_full", 32'(packet_sent), 1);
        tick();
        data_ready_in = 1'b0;
        chk("ret1_credits1_after", 32'(credits[1]), 0);
        chk("ret1_blocked", 32'(link_valid), 0);

        // vc 0 flit is queued behind blocked vc 1 head and must wait.
        popped_mark = popped;
        tick();
        tick();
        tick();
        chk("hol_no_send", 32'(popped - popped_mark), 0);
        chk("hol_credits0", 32'(credits[0]), 7);
        credit_return_valid = 1'b1;
        credit_return_vc    = 1'b1;
        tick();
        credit_return_valid = 1'b0;
        tick();
        tick();
        chk("hol_credits0_after", 32'(credits[0]), 6);
        chk("hol_credits1_after", 32'(credits[1]), 0);
        chk("hol_popped", 32'(popped - popped_mark), 2);
        chk("hol_sb_empty", 32'(exp_q.size()), 0);

        // Refill vc 1 to the cap.
        for (int i = 0; i < 8; i++) begin
            credit_return_valid = 1'b1;
            credit_return_vc    = 1'b1;
            tick();
        end
        credit_return_valid = 1'b0;
        tick();
        chk("refill_credits1", 32'(credits[1]), 8);
        chk("refill_no_overflow", 32'(credit_overflow), 0);

        // Same-cycle send and return on vc 0 at 5.
        flit_in       = mk(0, 50);
        data_ready_in = 1'b1;
        tick();
        data_ready_in = 1'b0;
        tick();
        chk("cancel_pre_credits0", 32'(credits[0]), 5);
        flit_in       = mk(0, 51);
        data_ready_in = 1'b1;
        tick();
        data_ready_in       = 1'b0;
        credit_return_valid = 1'b1;
        credit_return_vc    = 1'b0;
        #1;
        chk("cancel_link_valid", 32'(link_valid), 1);
        tick();
        credit_return_valid = 1'b0;
        chk("cancel_credits0", 32'(credits[0]), 5);
        chk("cancel_granted", 32'(credit_granted), 32'b01);

        // Return at the cap: dropped, sticky overflow, no pulse.
        for (int i = 0; i < 3; i++) begin
            credit_return_valid = 1'b1;
            credit_return_vc    = 1'b0;
            tick();
        end
        credit_return_valid = 1'b0;
        tick();
        chk("cap_credits0", 32'(credits[0]), 8);
        chk("cap_no_overflow_yet", 32'(credit_overflow), 0);
        credit_return_valid = 1'b1;
        credit_return_vc    = 1'b0;
        tick();
        credit_return_valid = 1'b0;
        chk("ovf_credits0", 32'(credits[0]), 8);
        chk("ovf_flag", 32'(credit_overflow), 1);
        chk("ovf_no_grant", 32'(credit_granted), 0);
        tick();
        tick();
        chk("ovf_sticky", 32'(credit_overflow), 1);

        // Stall with link_ready low, then reset mid-transfer.
        link_ready    = 1'b0;
        flit_in       = mk(1, 60);
        data_ready_in = 1'b1;
        tick();
        data_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(link_valid), 1);
            chk("stall_flit", 32'(link_flit), 32'(mk(1, 60)));
            chk("stall_credits1", 32'(credits[1]), 8);
            tick();
        end
        n_rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(link_valid), 0);
        chk("mid_rst_credits0", 32'(credits[0]), 8);
        chk("mid_rst_credits1", 32'(credits[1]), 8);
        chk("mid_rst_overflow", 32'(credit_overflow), 0);
        chk("mid_rst_granted", 32'(credit_granted), 0);
        exp_q.delete();
        n_rst       = 1'b0;
        link_ready  = 1'b1;
        popped_mark = popped;
        tick();
        tick();
        chk("post_rst_empty", 32'(link_valid), 0);
        chk("post_rst_no_pop", 32'(popped - popped_mark), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
